seq_left_shifter: RTL and testbench
===================================

# seq_left_shifter

Multi-cycle logical left shifter, the counterpart to our combinational logical right shifter. It accepts an operand and a shift amount over a valid/ready handshake and shifts left by one bit per clock, zero-filling from the LSB. It then presents the result, a lost-bits flag and a range-error flag over a second valid/ready handshake. It sits in the micro-ALU datapath where area matters more than latency.

## Interface
Parameters:
- DATA_W, 8, operand/result width
- SHAMT_W, 4, shift-amount width; legal amounts 0..DATA_W-1

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand/amount valid
- in_ready  out  1  block can accept; high only in IDLE and while rst low
- A  in  DATA_W  operand
- Shift_value  in  SHAMT_W  shift amount
- out_valid  out  1  result valid (state DONE)
- out_ready  in  1  consumer accepts result
- Result  out  DATA_W  shifted operand
- Lost_bits  out  1  sticky OR of every bit shifted out of the MSB
- Range_err  out  1  Shift_value > DATA_W-1; operand passed through unshifted

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: Result<=A, Lost_bits<=0, go SHIFT.
  - If Shift_value <= DATA_W-1: count<=Shift_value, Range_err<=0.
  - Else: count<=0, Range_err<=1.
- SHIFT:
  - count>0: Lost_bits<=Lost_bits|Result[DATA_W-1], Result<=Result<<1, count<=count-1, stay in SHIFT.
  - count==0: go DONE, no shift.
- DONE:
  - out_valid=1; Result, Lost_bits and Range_err held stable.
  - On out_ready: go IDLE.
- Width rules:
  - Bits shifted past DATA_W-1 are discarded and recorded only in Lost_bits.
  - Fill bits are always 0, so no sign preservation.
  - count is SHAMT_W bits wide.
- in_valid outside IDLE is ignored. A and Shift_value are sampled only at the accept edge.
- Out-of-range amount: no shifting, Result=A, Range_err=1. No simulation-only warning is required.

## Timing
- Reset (rst high at an edge): state=IDLE, Result=0, Lost_bits=0, Range_err=0, count=0, out_valid=0. in_ready is forced 0 while rst is high.
- Latency: with the accept in cycle 0, out_valid rises in cycle N+2 for N<=DATA_W-1, and in cycle 2 for an out-of-range amount.
- Throughput: one operation in flight.
  - A DONE→IDLE transition and a new accept never share a cycle.
  - The earliest next accept is the cycle after the out_ready handshake.
- out_valid stays high until out_ready is sampled high. Outputs do not change while out_valid=1 and out_ready=0.
- Reset mid-operation (SHIFT or DONE): the operation is abandoned, all outputs go to their reset values, and no result is delivered.
- out_ready high outside DONE has no effect.

## Structure
- Shared package shifter_pkg:
  - state enum (IDLE/SHIFT/DONE)
  - default DATA_W and SHAMT_W constants, shared with the right shifter
- Single module, no sub-module: one FSM plus one datapath register and a down-counter.

## Test plan
- A=0x81, Shift_value=1, out_ready=1 → out_valid in cycle 3, Result=0x02, Lost_bits=1, Range_err=0.
- A=0x0F, Shift_value=4 → out_valid in cycle 6, Result=0xF0, Lost_bits=0; in_ready=0 from cycles 1 through 6.
- A=0xA5, Shift_value=0 → out_valid in cycle 2, Result=0xA5, Lost_bits=0. Then A=0x3C, Shift_value=9 → Result=0x3C, Range_err=1, latency 2.
- Backpressure: A=0x01, Shift_value=7, out_ready held low 5 cycles after DONE.
  - Result=0x80 stable and out_valid held throughout.
  - in_valid pulses are ignored.
  - After out_ready=1, IDLE follows and the next operation is accepted the following cycle.
- Reset mid-shift: A=0xFF, Shift_value=7, rst=1 in cycle 4 → out_valid=0, Result=0, Lost_bits=0 next cycle; in_ready=1 once rst is low; a following A=0x01, Shift_value=2 yields 0x04.
- Back-to-back: three operations with in_valid held high and out_ready=1 → accepts separated by exactly N+3 cycles, all results correct.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the micro-ALU shifters (left and right).
package shifter_pkg;
  localparam int DATA_W_DEF  = 8;
  localparam int SHAMT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/seq_left_shifter.sv
// Multi-cycle logical left shifter: one bit per clock, zero fill,
// sticky lost-bit flag and range-error pass-through.
module seq_left_shifter
  import shifter_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  A,
  input  logic [SHAMT_W-1:0] Shift_value,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  Result,
  output logic               Lost_bits,
  output logic               Range_err
);

  // Largest legal amount, one bit wider than the amount so the compare
  // cannot wrap when DATA_W-1 does not fit in SHAMT_W bits.
  localparam logic [SHAMT_W:0] MAX_SH = (SHAMT_W+1)'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic                lost_q, lost_d;
  logic                rerr_q, rerr_d;
  logic                oor;

  assign oor = {1'b0, Shift_value} > MAX_SH;

  // State, datapath and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      lost_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
      rerr_q  <= rerr_d;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    rerr_d  = rerr_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && !rst) begin
          res_d   = A;
          lost_d  = 1'b0;
          state_d = SHIFT;
          if (oor) begin
            cnt_d  = '0;
            rerr_d = 1'b1;
          end else begin
            cnt_d  = Shift_value;
            rerr_d = 1'b0;
          end
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          lost_d = lost_q | res_q[DATA_W-1];
          res_d  = res_q << 1;
          cnt_d  = cnt_q - SHAMT_W'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign Result    = res_q;
  assign Lost_bits = lost_q;
  assign Range_err = rerr_q;

endmodule

// File: tb/tb_seq_left_shifter.sv
// Scoreboard bench for seq_left_shifter: driver pushes expected results at
// accept, monitor pops and compares at each output handshake.
module tb_seq_left_shifter;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] A;
  logic [3:0] Shift_value;
  logic       out_valid, out_ready;
  logic [7:0] Result;
  logic       Lost_bits, Range_err;

  seq_left_shifter #(.DATA_W(8), .SHAMT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .Shift_value(Shift_value), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .Lost_bits(Lost_bits),
    .Range_err(Range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       lost;
    logic       rerr;
    int         lat;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  int   hs_cyc = -100, last_acc = -100, last_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: latency on out_valid rise, hold stability, busy in_ready, result pop.
  logic       prev_ov = 1'b0;
  logic [9:0] held;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && cyc > exp_q[0].acc)
        chk("in_ready_busy", in_ready, 0);
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) chk("spurious_out_valid", out_valid, 0);
        else chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
      end
      if (out_valid && prev_ov)
        chk("hold_stable", {Result, Lost_bits, Range_err}, held);
      if (out_valid && out_ready) begin
        hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", out_valid, 0);
        end else begin
          chk("Result",    Result,    exp_q[0].res);
          chk("Lost_bits", Lost_bits, exp_q[0].lost);
          chk("Range_err", Range_err, exp_q[0].rerr);
          void'(exp_q.pop_front());
        end
      end
    end
    prev_ov = out_valid;
    held    = {Result, Lost_bits, Range_err};
  end

  // mode 0: no gap check; 1: back-to-back gap from previous accept;
  // 2: accept must follow the last output handshake by one cycle.
  task automatic do_op(input logic [7:0] a, input logic [3:0] s,
                       input logic [7:0] er, input logic el, input logic erg,
                       input int mode, input bit hold);
    exp_t e;
    int   t = 0;
    int   n = (s <= 4'd7) ? int'(s) : 0;
    A = a; Shift_value = s; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      e.res = er; e.lost = el; e.rerr = erg; e.lat = n + 2; e.acc = cyc;
      exp_q.push_back(e);
      if (mode == 1) chk("b2b_gap", cyc - last_acc, last_n + 3);
      if (mode == 2) chk("accept_after_hs", cyc - hs_cyc, 1);
      last_acc = cyc; last_n = n;
    end
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 200) begin @(negedge clk); t++; end
    if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; Shift_value = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_Result",    Result,    0);
    chk("rst_Lost",      Lost_bits, 0);
    chk("rst_Range",     Range_err, 0);
    chk("rst_in_ready",  in_ready,  0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Basic shifts, zero shift, out-of-range
    do_op(8'h81, 4'd1, 8'h02, 1'b1, 1'b0, 0, 0); drain();
    do_op(8'h0F, 4'd4, 8'hF0, 1'b0, 1'b0, 0, 0); drain();
    do_op(8'hA5, 4'd0, 8'hA5, 1'b0, 1'b0, 0, 0); drain();
    do_op(8'h3C, 4'd9, 8'h3C, 1'b0, 1'b1, 0, 0); drain();
    do_op(8'hC3, 4'd15, 8'hC3, 1'b0, 1'b1, 0, 0); drain();

    // Backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    do_op(8'h01, 4'd7, 8'h80, 1'b0, 1'b0, 0, 0);
    begin
      int t = 0;
      @(negedge clk);
      while (!out_valid && t < 50) begin @(negedge clk); t++; end
      chk("bp_out_valid", out_valid, 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = (i % 2 == 0); A = 8'hFF; Shift_value = 4'd1;
      @(negedge clk);
      chk("bp_out_valid_held", out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    do_op(8'h22, 4'd3, 8'h10, 1'b1, 1'b0, 2, 0); drain();

    // Reset in the middle of a shift
    do_op(8'hFF, 4'd7, 8'h80, 1'b1, 1'b0, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_Result",    Result,    0);
    chk("midrst_Lost",      Lost_bits, 0);
    chk("midrst_in_ready",  in_ready,  0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("postrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    do_op(8'h01, 4'd2, 8'h04, 1'b0, 1'b0, 0, 0); drain();

    // Back-to-back with in_valid held high
    do_op(8'h81, 4'd1, 8'h02, 1'b1, 1'b0, 0, 1);
    do_op(8'h0F, 4'd4, 8'hF0, 1'b0, 1'b0, 1, 1);
    do_op(8'h3C, 4'd9, 8'h3C, 1'b0, 1'b1, 1, 0);
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
